branch_resolve_unit: RTL and testbench

Pipelined, parametrised branch resolution unit; successor to the single-cycle branch comparator in the core data path. Evaluates all six RV32I/RV64I conditional-branch conditions with correct signed and unsigned semantics. Also computes the branch target, checks it against the fetch-stage prediction, and emits a redirect. Sits between the execute-stage operand muxes and the fetch redirect logic, with valid/ready handshakes on both sides and flush support.

---
 rtl/core_pkg.sv | 31 +++
 rtl/branch_cond.sv | 38 +++
 rtl/branch_resolve_unit.sv | 199 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared branch-unit types: func3 encodings and the width-independent
// request/result flag bundles carried through the branch pipeline.
// No logic; XLEN-wide data travels alongside these structs in the parent.
package core_pkg;

  // RV32I/RV64I conditional-branch func3 encodings (010/011 are reserved)
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_func3_e;

  // Flags captured in S1 when a request is accepted
  typedef struct packed {
    logic cond;        // raw condition result
    logic illegal;     // reserved func3
    logic pred_taken;  // fetch-stage direction prediction
  } br_req_t;

  // Flags presented at the S2 output
  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
    logic misaligned;
  } br_res_t;

endpackage

// File: rtl/branch_cond.sv
// Purpose : combinational evaluation of the six conditional-branch conditions.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller owns all handshaking.
// Ports   : rs1/rs2 operands, func3 selector -> cond result, illegal for 010/011.
module branch_cond #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func3,
  output logic            cond,
  output logic            illegal
);
  import core_pkg::*;

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (func3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: illegal = 1'b1;  // 010 / 011: never taken
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Purpose : two-stage branch resolution: condition, target, redirect, mispredict, stats.
// Latency : 2 cycles from input transfer to out_valid; 1 request/cycle throughput.
// Backpr. : valid/ready; each stage advances when empty or draining, outputs hold while stalled.
// Ports   : in_valid/in_ready + rs1/rs2/func3/pc/imm/pred_* request; out_valid/out_ready +
//           taken/target/redirect_pc/mispredict/illegal/misaligned result; flush kills
//           in-flight work; cnt_clear zeroes branch_cnt/mispred_cnt.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int IMM_WIDTH = 13,
  parameter int CNT_WIDTH = 16,
  parameter int C_EXT     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      rs1,
  input  logic [XLEN-1:0]      rs2,
  input  logic [2:0]           func3,
  input  logic [XLEN-1:0]      pc,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic                 pred_taken,
  input  logic [XLEN-1:0]      pred_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 taken,
  output logic [XLEN-1:0]      target,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 mispredict,
  output logic                 illegal,
  output logic                 misaligned,
  input  logic                 flush,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);
  import core_pkg::*;

  // ---------------- condition evaluation (input side) ----------------
  logic cond_in;
  logic illegal_in;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .rs1     (rs1),
    .rs2     (rs2),
    .func3   (func3),
    .cond    (cond_in),
    .illegal (illegal_in)
  );

  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] target_in;
  logic [XLEN-1:0] pc4_in;

  assign imm_sext  = {{(XLEN-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign target_in = pc + imm_sext;   // wraps modulo 2^XLEN
  assign pc4_in    = pc + XLEN'(4);

  // ---------------- pipeline state ----------------
  logic            s1_valid_q, s1_valid_d;
  br_req_t         s1_req_q, s1_req_d;
  logic [XLEN-1:0] s1_target_q, s1_target_d;
  logic [XLEN-1:0] s1_pc4_q, s1_pc4_d;
  logic [XLEN-1:0] s1_pred_target_q, s1_pred_target_d;

  logic            s2_valid_q, s2_valid_d;
  br_res_t         s2_res_q, s2_res_d;
  logic [XLEN-1:0] s2_target_q, s2_target_d;
  logic [XLEN-1:0] s2_redirect_q, s2_redirect_d;

  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  // Handshake: S2 drains on out_ready, S1 moves when S2 is empty or draining.
  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  assign s2_adv   = s2_valid_q & out_ready;
  assign s1_adv   = s1_valid_q & (!s2_valid_q | out_ready);
  assign in_ready = !s1_valid_q | s1_adv;
  // A request presented alongside flush is dropped even though in_ready is high.
  assign in_fire  = in_valid & in_ready & !flush;

  // ---------------- S2 resolution from S1 contents ----------------
  logic s1_taken;
  logic s1_mispredict;
  logic s1_misaligned;

  assign s1_taken      = s1_req_q.cond & !s1_req_q.illegal;
  assign s1_mispredict = (s1_taken != s1_req_q.pred_taken) |
                         (s1_taken & s1_req_q.pred_taken & (s1_target_q != s1_pred_target_q));
  // Bit 0 of a branch target is zero by construction; only bit 1 matters without C.
  assign s1_misaligned = (C_EXT == 0) ? (s1_taken & s1_target_q[1]) : 1'b0;

  always_comb begin
    s1_valid_d       = s1_valid_q;
    s1_req_d         = s1_req_q;
    s1_target_d      = s1_target_q;
    s1_pc4_d         = s1_pc4_q;
    s1_pred_target_d = s1_pred_target_q;

    s2_valid_d       = s2_valid_q;
    s2_res_d         = s2_res_q;
    s2_target_d      = s2_target_q;
    s2_redirect_d    = s2_redirect_q;

    // S1
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_req_d.cond       = cond_in;
      s1_req_d.illegal    = illegal_in;
      s1_req_d.pred_taken = pred_taken;
      s1_target_d         = target_in;
      s1_pc4_d            = pc4_in;
      s1_pred_target_d    = pred_target;
    end

    // S2
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_adv) begin
      s2_valid_d = 1'b1;
    end else if (s2_adv) begin
      s2_valid_d = 1'b0;
    end
    if (s1_adv && !flush) begin
      s2_res_d.taken      = s1_taken;
      s2_res_d.mispredict = s1_mispredict;
      s2_res_d.illegal    = s1_req_q.illegal;
      s2_res_d.misaligned = s1_misaligned;
      s2_target_d         = s1_target_q;
      s2_redirect_d       = s1_taken ? s1_target_q : s1_pc4_q;
    end
  end

  // ---------------- statistics ----------------
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (cnt_clear) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (s2_adv) begin
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
      if (s2_res_q.mispredict && (mispred_cnt_q != '1)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q       <= 1'b0;
      s1_req_q         <= '0;
      s1_target_q      <= '0;
      s1_pc4_q         <= '0;
      s1_pred_target_q <= '0;
      s2_valid_q       <= 1'b0;
      s2_res_q         <= '0;
      s2_target_q      <= '0;
      s2_redirect_q    <= '0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      s1_valid_q       <= s1_valid_d;
      s1_req_q         <= s1_req_d;
      s1_target_q      <= s1_target_d;
      s1_pc4_q         <= s1_pc4_d;
      s1_pred_target_q <= s1_pred_target_d;
      s2_valid_q       <= s2_valid_d;
      s2_res_q         <= s2_res_d;
      s2_target_q      <= s2_target_d;
      s2_redirect_q    <= s2_redirect_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  // ---------------- registered outputs ----------------
  assign out_valid   = s2_valid_q;
  assign taken       = s2_res_q.taken;
  assign mispredict  = s2_res_q.mispredict;
  assign illegal     = s2_res_q.illegal;
  assign misaligned  = s2_res_q.misaligned;
  assign target      = s2_target_q;
  assign redirect_pc = s2_redirect_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (XLEN=32, CNT_WIDTH=4, C_EXT=0).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1, rs2;
  logic [2:0]  func3;
  logic [31:0] pc;
  logic [12:0] imm;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] target;
  logic [31:0] redirect_pc;
  logic        mispredict;
  logic        illegal;
  logic        misaligned;
  logic        flush;
  logic        cnt_clear;
  logic [3:0]  branch_cnt;
  logic [3:0]  mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN(32), .IMM_WIDTH(13), .CNT_WIDTH(4), .C_EXT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .func3(func3), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .target(target), .redirect_pc(redirect_pc),
    .mispredict(mispredict), .illegal(illegal), .misaligned(misaligned),
    .flush(flush), .cnt_clear(cnt_clear),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [12:0] im,
                      input logic pt, input logic [31:0] ptg);
    func3 = f; rs1 = a; rs2 = b; pc = p; imm = im;
    pred_taken = pt; pred_target = ptg;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Stream table: rs1 = index, rs2 = 3, hand-evaluated directions
  logic [2:0] s_f3 [8];
  logic       s_tk [8];

  initial begin
    int  sent, got, cyc;
    bit  saw_block, stalled_prev;
    logic [31:0] hold_rp;
    logic [31:0] exp_rp;

    s_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b100};
    s_tk = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; cnt_clear = 1'b0;
    rs1 = '0; rs2 = '0; func3 = '0; pc = '0; imm = '0; pred_taken = 1'b0; pred_target = '0;
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    // ---- reset state ----
    chk("rst_out_valid", out_valid, 0);
    chk("rst_taken", taken, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_target", target, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // ---- signed vs unsigned compare ----
    send(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 13'h010, 1'b1, 32'h210);
    chk("blt_lat1_out_valid", out_valid, 0);
    tick();
    chk("blt_out_valid", out_valid, 1);
    chk("blt_taken", taken, 1);
    chk("blt_target", target, 32'h210);
    chk("blt_redirect", redirect_pc, 32'h210);
    chk("blt_mispredict", mispredict, 0);
    send(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 13'h010, 1'b0, 32'h0);
    tick();
    chk("bltu_out_valid", out_valid, 1);
    chk("bltu_taken", taken, 0);
    chk("bltu_redirect", redirect_pc, 32'h204);
    chk("bltu_mispredict", mispredict, 0);
    tick();
    chk("t1_branch_cnt", branch_cnt, 2);
    chk("t1_mispred_cnt", mispred_cnt, 0);

    // ---- BEQ with negative offset, mispredicted ----
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    chk("clr_branch_cnt", branch_cnt, 0);
    send(3'b000, 32'd5, 32'd5, 32'h100, 13'h1FF8, 1'b0, 32'h0);
    tick();
    chk("beq_taken", taken, 1);
    chk("beq_target", target, 32'hF8);
    chk("beq_redirect", redirect_pc, 32'hF8);
    chk("beq_mispredict", mispredict, 1);
    tick();
    chk("beq_branch_cnt", branch_cnt, 1);
    chk("beq_mispred_cnt", mispred_cnt, 1);

    // ---- illegal func3, misalignment, wrap, signed BGE, target mismatch ----
    send(3'b010, 32'd0, 32'd0, 32'h40, 13'h008, 1'b1, 32'h48);
    tick();
    chk("ill_illegal", illegal, 1);
    chk("ill_taken", taken, 0);
    chk("ill_mispredict", mispredict, 1);
    chk("ill_redirect", redirect_pc, 32'h44);
    chk("ill_misaligned", misaligned, 0);
    send(3'b000, 32'd0, 32'd0, 32'h0, 13'h006, 1'b1, 32'h6);
    tick();
    chk("mis_taken", taken, 1);
    chk("mis_target", target, 32'h6);
    chk("mis_misaligned", misaligned, 1);
    chk("mis_mispredict", mispredict, 0);
    chk("mis_illegal", illegal, 0);
    send(3'b001, 32'd7, 32'd7, 32'hFFFF_FFFC, 13'h010, 1'b0, 32'h0);
    tick();
    chk("wrap_taken", taken, 0);
    chk("wrap_redirect", redirect_pc, 32'h0);
    chk("wrap_target", target, 32'hC);
    send(3'b101, 32'h8000_0000, 32'h0, 32'h500, 13'h020, 1'b1, 32'h520);
    tick();
    chk("bge_taken", taken, 0);
    chk("bge_mispredict", mispredict, 1);
    chk("bge_redirect", redirect_pc, 32'h504);
    send(3'b100, 32'hFFFF_FFFF, 32'h0, 32'h300, 13'h040, 1'b1, 32'h999);
    tick();
    chk("tgt_taken", taken, 1);
    chk("tgt_mispredict", mispredict, 1);
    tick();

    // ---- back-to-back stream with a 3-cycle consumer stall ----
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    sent = 0; got = 0; cyc = 0; saw_block = 0; stalled_prev = 0; hold_rp = '0;
    while (got < 8 && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        func3 = s_f3[sent]; rs1 = 32'(sent); rs2 = 32'd3;
        pc = 32'h1000 + 32'(16 * sent); imm = 13'h020;
        pred_taken = 1'b0; pred_target = '0;
      end
      #1;
      if (in_valid && !in_ready) saw_block = 1;
      if (out_valid && out_ready) begin
        exp_rp = s_tk[got] ? (32'h1020 + 32'(16 * got)) : (32'h1004 + 32'(16 * got));
        chk("stream_taken", taken, s_tk[got]);
        chk("stream_redirect", redirect_pc, exp_rp);
        got++;
      end
      if (out_valid && !out_ready) begin
        if (stalled_prev) chk("stall_hold", redirect_pc, hold_rp);
        hold_rp = redirect_pc;
        stalled_prev = 1;
      end else begin
        stalled_prev = 0;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_all_received", got, 8);
    chk("stream_in_ready_dropped", saw_block, 1);
    chk("stream_branch_cnt", branch_cnt, 8);
    chk("stream_mispred_cnt", mispred_cnt, 4);

    // ---- flush with two in flight and a third presented ----
    out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd1, 32'h2000, 13'h010, 1'b0, 32'h0);
    send(3'b000, 32'd1, 32'd1, 32'h2010, 13'h010, 1'b0, 32'h0);
    func3 = 3'b000; rs1 = 32'd1; rs2 = 32'd1; pc = 32'h2020;
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid_0", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    tick();
    chk("flush_out_valid_1", out_valid, 0);
    tick();
    chk("flush_out_valid_2", out_valid, 0);
    chk("flush_branch_cnt", branch_cnt, 8);
    chk("flush_mispred_cnt", mispred_cnt, 4);

    // ---- counter saturation (CNT_WIDTH=4) ----
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    func3 = 3'b000; rs1 = 32'd1; rs2 = 32'd1; pc = 32'h3000; imm = 13'h010;
    pred_taken = 1'b0; pred_target = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("sat_branch_cnt", branch_cnt, 15);
    chk("sat_mispred_cnt", mispred_cnt, 15);

    // ---- clear coincident with a transfer ----
    send(3'b000, 32'd1, 32'd1, 32'h3000, 13'h010, 1'b0, 32'h0);
    tick();
    chk("clr_xfer_out_valid", out_valid, 1);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("clr_xfer_drained", out_valid, 0);
    chk("clr_xfer_branch_cnt", branch_cnt, 0);
    chk("clr_xfer_mispred_cnt", mispred_cnt, 0);

    // ---- asynchronous reset with a result pending ----
    out_ready = 1'b0;
    send(3'b000, 32'd2, 32'd2, 32'h4000, 13'h010, 1'b0, 32'h0);
    tick();
    chk("arst_pre_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_taken", taken, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_post_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
